hazard_sched: RTL and testbench

HAZARD_SCHED -- requirements
Module: hazard_sched

---
 rtl/hazard_sched.sv | 146 ++++++++++++++
 tb/tb_hazard_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_sched: pipeline hazard scheduler (load-use, branch, memory wait)  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module hazard_sched #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memReadEX,
  input  logic [2:0]       rdEX,
  input  logic [2:0]       r1ID,
  input  logic [2:0]       r2ID,
  input  logic             usesR2ID,
  input  logic             takenEX,
  input  logic             memReqMEM,
  input  logic             memAckMEM,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             flushIFID,
  output logic             flushIDEX,
  output logic             pcSel,
  output logic             freeze,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  localparam logic [8:0] c_TIMEOUT = 9'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             w_load_use;
  logic             w_mem_stall;
  logic [8:0]       w_wait_next;

  assign w_load_use  = memReadEX && (rdEX != 3'd0) &&
                       ((rdEX == r1ID) || (usesR2ID && (rdEX == r2ID)));
  assign w_mem_stall = memReqMEM && !memAckMEM;
  assign w_wait_next = {1'b0, wait_cnt_q} + 9'd1;

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    flushIFID  = 1'b0;
    flushIDEX  = 1'b0;
    pcSel      = 1'b0;
    freeze     = 1'b0;
    memErr     = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      RUN: begin
        if (w_mem_stall) begin
          freeze     = 1'b1;
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          state_d    = MEMWAIT;
          wait_cnt_d = 8'd0;
        end else if (takenEX) begin
          // ID holds a wrong-path instruction, so any load-use hit is moot
          pcSel     = 1'b1;
          flushIFID = 1'b1;
          flushIDEX = 1'b1;
        end else if (w_load_use) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          flushIDEX = 1'b1;
        end
      end
      MEMWAIT: begin
        freeze     = 1'b1;
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        wait_cnt_d = w_wait_next[7:0];
        // An ack in the timeout cycle still wins over the error
        if (memAckMEM) begin
          state_d = RUN;
        end else if (w_wait_next >= c_TIMEOUT) begin
          state_d = ERR;
        end
      end
      ERR: begin
        freeze    = 1'b1;
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        memErr    = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset drains the pipeline with bubbles
    if (!rst) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      flushIFID = 1'b1;
      flushIDEX = 1'b1;
      pcSel     = 1'b0;
      freeze    = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pcWrite && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flushIFID && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign stallCycles = stall_q;
  assign flushCount  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_sched: checks two hazard_sched configurations against a model  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       memReadEX;
  logic [2:0] rdEX, r1ID, r2ID;
  logic       usesR2ID, takenEX, memReqMEM, memAckMEM;

  logic        pcWrite_a, ifidWrite_a, flushIFID_a, flushIDEX_a, pcSel_a, freeze_a, memErr_a;
  logic [15:0] stall_a, flush_a;
  logic        pcWrite_b, ifidWrite_b, flushIFID_b, flushIDEX_b, pcSel_b, freeze_b, memErr_b;
  logic [3:0]  stall_b, flush_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: mode 0=run, 1=waiting on memory, 2=error
  int mode[2], wcnt[2], stl[2], flc[2];
  int to_p[2] = '{15, 3};
  int maxv[2] = '{65535, 15};

  always #5 clk = ~clk;

  hazard_sched u_dut_a (
    .clk(clk), .rst(rst), .memReadEX(memReadEX), .rdEX(rdEX), .r1ID(r1ID), .r2ID(r2ID),
    .usesR2ID(usesR2ID), .takenEX(takenEX), .memReqMEM(memReqMEM), .memAckMEM(memAckMEM),
    .pcWrite(pcWrite_a), .ifidWrite(ifidWrite_a), .flushIFID(flushIFID_a),
    .flushIDEX(flushIDEX_a), .pcSel(pcSel_a), .freeze(freeze_a), .memErr(memErr_a),
    .stallCycles(stall_a), .flushCount(flush_a)
  );

  hazard_sched #(.MEM_TIMEOUT(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .memReadEX(memReadEX), .rdEX(rdEX), .r1ID(r1ID), .r2ID(r2ID),
    .usesR2ID(usesR2ID), .takenEX(takenEX), .memReqMEM(memReqMEM), .memAckMEM(memAckMEM),
    .pcWrite(pcWrite_b), .ifidWrite(ifidWrite_b), .flushIFID(flushIFID_b),
    .flushIDEX(flushIDEX_b), .pcSel(pcSel_b), .freeze(freeze_b), .memErr(memErr_b),
    .stallCycles(stall_b), .flushCount(flush_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {pcWrite, ifidWrite, flushIFID, flushIDEX, pcSel, freeze, memErr}
  function automatic logic [6:0] exp_out(input int k);
    bit hazard;
    bit err;
    hazard = memReadEX && (rdEX != 0) && (rdEX == r1ID || (usesR2ID && rdEX == r2ID));
    err    = (mode[k] == 2);
    if (!rst)                         return {6'b00_1100, err};
    if (mode[k] != 0)                 return {6'b00_0001, err};
    if (memReqMEM && !memAckMEM)      return 7'b00_0001_0;
    if (takenEX)                      return 7'b11_1110_0;
    if (hazard)                       return 7'b00_0100_0;
    return 7'b11_0000_0;
  endfunction

  task automatic model_edge();
    logic [6:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_out(k);
      if (!rst) begin
        mode[k] = 0; wcnt[k] = 0; stl[k] = 0; flc[k] = 0;
      end else begin
        if (!e[6] && stl[k] < maxv[k]) stl[k]++;
        if (e[4] && flc[k] < maxv[k]) flc[k]++;
        if (mode[k] == 0) begin
          if (memReqMEM && !memAckMEM) begin
            mode[k] = 1; wcnt[k] = 0;
          end
        end else if (mode[k] == 1) begin
          wcnt[k]++;
          if (memAckMEM) mode[k] = 0;
          else if (wcnt[k] >= to_p[k]) mode[k] = 2;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check("outA", 32'({pcWrite_a, ifidWrite_a, flushIFID_a, flushIDEX_a, pcSel_a, freeze_a, memErr_a}), 32'(exp_out(0)));
    check("outB", 32'({pcWrite_b, ifidWrite_b, flushIFID_b, flushIDEX_b, pcSel_b, freeze_b, memErr_b}), 32'(exp_out(1)));
    check("stallA", 32'(stall_a), 32'(stl[0]));
    check("flushA", 32'(flush_a), 32'(flc[0]));
    check("stallB", 32'(stall_b), 32'(stl[1]));
    check("flushB", 32'(flush_b), 32'(flc[1]));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; memReadEX = 1'b0; rdEX = 3'd0; r1ID = 3'd0; r2ID = 3'd0;
    usesR2ID = 1'b0; takenEX = 1'b0; memReqMEM = 1'b0; memAckMEM = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; wcnt[k] = 0; stl[k] = 0; flc[k] = 0;
    end
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    check("rst_stall", 32'(stall_a), 32'd0);
    rst = 1'b1;

    // Load-use on r1: one bubble
    memReadEX = 1'b1; rdEX = 3'd3; r1ID = 3'd3;
    cycle();
    idle();
    check("lu_stall", 32'(stall_a), 32'd1);
    check("lu_flush", 32'(flush_a), 32'd0);
    cycle();

    // Register 0 never hazards
    memReadEX = 1'b1; rdEX = 3'd0; r1ID = 3'd0;
    cycle();
    idle();
    check("r0_stall", 32'(stall_a), 32'd1);

    // Load-use on r2 gated by usesR2ID
    memReadEX = 1'b1; rdEX = 3'd5; r1ID = 3'd1; r2ID = 3'd5; usesR2ID = 1'b0;
    cycle();
    usesR2ID = 1'b1;
    cycle();
    idle();

    // Taken branch with coincident load-use
    memReadEX = 1'b1; rdEX = 3'd2; r1ID = 3'd2; takenEX = 1'b1;
    cycle();
    idle();
    check("br_flush", 32'(flush_a), 32'd1);
    check("br_stall", 32'(stall_a), 32'd2);
    cycle();

    // Memory wait: four cycles without ack, then ack
    do_reset();
    memReqMEM = 1'b1;
    repeat (4) cycle();
    memAckMEM = 1'b1;
    cycle();
    idle();
    check("mw_stall", 32'(stall_a), 32'd5);
    check("mw_err", 32'(memErr_a), 32'd0);
    check("to_err", 32'(memErr_b), 32'd1);
    memAckMEM = 1'b1;
    repeat (3) cycle();
    check("to_sticky", 32'(memErr_b), 32'd1);
    idle();

    // Saturation then reset in the middle of a memory wait
    do_reset();
    memReadEX = 1'b1; rdEX = 3'd4; r1ID = 3'd4;
    repeat (20) cycle();
    check("sat_b", 32'(stall_b), 32'd15);
    check("sat_a", 32'(stall_a), 32'd20);
    idle();
    memReqMEM = 1'b1;
    cycle(); cycle();
    rst = 1'b0; memAckMEM = 1'b1;
    cycle();
    idle();
    check("rst_mw_stall_a", 32'(stall_a), 32'd0);
    check("rst_mw_stall_b", 32'(stall_b), 32'd0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) != 0);
      memReadEX = ($urandom_range(0, 1) == 1);
      rdEX      = 3'($urandom_range(0, 3));
      r1ID      = 3'($urandom_range(0, 3));
      r2ID      = 3'($urandom_range(0, 3));
      usesR2ID  = ($urandom_range(0, 1) == 1);
      takenEX   = ($urandom_range(0, 3) == 0);
      memReqMEM = ($urandom_range(0, 9) < 4);
      memAckMEM = ($urandom_range(0, 9) < 3);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
